// File: rtl/fifo_wr_ctrl.sv
// Write-side control for the async FIFO: write pointer (binary and Gray),
// read-pointer synchroniser, and full / almost-full / count / overflow status.
//
// Ports:
//   wclk, wrst_n   write clock, async active-low reset
//   w_en           producer write request
//   g_rptr_async   Gray read pointer from the read clock domain
//   mem_we         memory write enable (w_en & ~full)
//   b_wptr, g_wptr registered binary / Gray write pointers
//   full           registered full flag
//   almost_full    registered fill >= AFULL_THRESH
//   wr_count       registered fill count seen from the write domain
//   overflow       sticky: write attempted while full
module fifo_wr_ctrl #(
    parameter int DEPTH        = 8,
    parameter int PTR_WIDTH    = 3,
    parameter int AFULL_THRESH = 6
) (
    input  logic               wclk,
    input  logic               wrst_n,
    input  logic               w_en,
    input  logic [PTR_WIDTH:0] g_rptr_async,
    output logic               mem_we,
    output logic [PTR_WIDTH:0] b_wptr,
    output logic [PTR_WIDTH:0] g_wptr,
    output logic               full,
    output logic               almost_full,
    output logic [PTR_WIDTH:0] wr_count,
    output logic               overflow
);

    localparam int P = PTR_WIDTH;
    localparam int AF_LIM = (AFULL_THRESH > DEPTH) ? DEPTH : AFULL_THRESH;
    localparam logic [P:0] AF_TH = (P+1)'(AF_LIM);

    // Two-stage synchroniser; stage 1 feeds the status computation so that
    // the registered status always matches what stage 2 holds.
    logic [P:0] sync_q [0:1];

    logic [P:0] b_next;
    logic [P:0] g_next;
    logic [P:0] r_bin;
    logic [P:0] cnt_next;
    logic       full_next;

    function automatic logic [P:0] gray2bin(input logic [P:0] g);
        logic [P:0] b;
        b[P] = g[P];
        for (int i = P - 1; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    assign mem_we = w_en & ~full;

    always_comb begin
        b_next    = b_wptr + {{P{1'b0}}, mem_we};
        g_next    = b_next ^ (b_next >> 1);
        r_bin     = gray2bin(sync_q[0]);
        cnt_next  = b_next - r_bin;
        // Full when write Gray equals read Gray with its two MSBs inverted.
        full_next = (g_next == {~sync_q[0][P:P-1], sync_q[0][P-2:0]});
    end

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            sync_q[0]   <= '0;
            sync_q[1]   <= '0;
            b_wptr      <= '0;
            g_wptr      <= '0;
            full        <= 1'b0;
            almost_full <= 1'b0;
            wr_count    <= '0;
            overflow    <= 1'b0;
        end else begin
            sync_q[0]   <= g_rptr_async;
            sync_q[1]   <= sync_q[0];
            b_wptr      <= b_next;
            g_wptr      <= g_next;
            full        <= full_next;
            almost_full <= (cnt_next >= AF_TH);
            wr_count    <= cnt_next;
            if (w_en && full) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Self-checking bench for fifo_wr_ctrl using an integer occupancy model.
// Directed scenarios plus a randomized writer/reader run.
module tb_fifo_wr_ctrl;

    logic       wclk;
    logic       wrst_n;
    logic       w_en;
    logic [3:0] g_rptr_async;
    logic       mem_we;
    logic [3:0] b_wptr;
    logic [3:0] g_wptr;
    logic       full;
    logic       almost_full;
    logic [3:0] wr_count;
    logic       overflow;

    int total = 0;
    int bad = 0;

    // Reference model: total writes accepted, read position seen one edge
    // ago (the value captured by the first sync stage), and status.
    int m_wr;
    int m_rd_s1;
    int m_cnt;
    bit m_full;
    bit m_af;
    bit m_ovf;
    int rd_cur;
    bit exp_we;

    fifo_wr_ctrl #(
        .DEPTH(8),
        .PTR_WIDTH(3),
        .AFULL_THRESH(6)
    ) dut (
        .wclk(wclk),
        .wrst_n(wrst_n),
        .w_en(w_en),
        .g_rptr_async(g_rptr_async),
        .mem_we(mem_we),
        .b_wptr(b_wptr),
        .g_wptr(g_wptr),
        .full(full),
        .almost_full(almost_full),
        .wr_count(wr_count),
        .overflow(overflow)
    );

    initial wclk = 1'b0;
    always #5 wclk = ~wclk;

    function automatic logic [3:0] gray(input int v);
        logic [3:0] b;
        b = v[3:0];
        return b ^ (b >> 1);
    endfunction

    function automatic logic [14:0] exp_vec();
        logic [3:0] b;
        logic [3:0] c;
        b = m_wr[3:0];
        c = m_cnt[3:0];
        return {b, gray(m_wr), m_full, m_af, c, m_ovf};
    endfunction

    function automatic logic [14:0] dut_vec();
        return {b_wptr, g_wptr, full, almost_full, wr_count, overflow};
    endfunction

    task automatic model_reset();
        m_wr = 0;
        m_rd_s1 = 0;
        m_cnt = 0;
        m_full = 0;
        m_af = 0;
        m_ovf = 0;
        rd_cur = 0;
    endtask

    task automatic drive(input bit we, input int rd);
        w_en = we;
        rd_cur = rd;
        g_rptr_async = gray(rd);
        exp_we = we && !m_full;
        #1;
    endtask

    task automatic tick();
        @(posedge wclk);
        if (w_en && m_full) m_ovf = 1;
        if (w_en && !m_full) m_wr++;
        m_cnt = m_wr - m_rd_s1;
        m_full = (m_cnt == 8);
        m_af = (m_cnt >= 6);
        m_rd_s1 = rd_cur;
        #1;
    endtask

    task automatic do_reset();
        w_en = 0;
        g_rptr_async = '0;
        wrst_n = 0;
        model_reset();
        #2;
        wrst_n = 1;
        #1;
    endtask

    task automatic test_reset();
        wrst_n = 0;
        w_en = 1;
        g_rptr_async = 4'($urandom_range(0, 15));
        model_reset();
        #3;
        total++;
        if (dut_vec() !== 15'd0 || mem_we !== 1'b1) begin
            bad++;
            $display("FAIL reset_state got=%h we=%b want=0000 we=1",
                     dut_vec(), mem_we);
        end
        @(posedge wclk);
        #1;
        total++;
        if (dut_vec() !== 15'd0) begin
            bad++;
            $display("FAIL reset_held got=%h want=0", dut_vec());
        end
        g_rptr_async = '0;
        #1;
        wrst_n = 1;
        drive(1, 0);
        tick();
        total++;
        if (b_wptr !== 4'd1 || g_wptr !== 4'b0001) begin
            bad++;
            $display("FAIL first_write b=%b g=%b want b=0001 g=0001",
                     b_wptr, g_wptr);
        end
    endtask

    task automatic test_fill();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            drive(1, 0);
            tick();
            total++;
            if (dut_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL fill_step%0d got=%h want=%h",
                         i, dut_vec(), exp_vec());
            end
            if (i == 4 || i == 5) begin
                total++;
                if (almost_full !== (i == 5)) begin
                    bad++;
                    $display("FAIL fill_afull%0d got=%b want=%b",
                             i, almost_full, (i == 5));
                end
            end
        end
        total++;
        if (full !== 1'b1 || wr_count !== 4'd8 ||
            b_wptr !== 4'b1000 || g_wptr !== 4'b1100) begin
            bad++;
            $display("FAIL fill_end full=%b cnt=%0d b=%b g=%b want 1 8 1000 1100",
                     full, wr_count, b_wptr, g_wptr);
        end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 3; i++) begin
            drive(1, 0);
            total++;
            if (mem_we !== 1'b0) begin
                bad++;
                $display("FAIL ovf_we%0d got=%b want=0", i, mem_we);
            end
            tick();
            total++;
            if (b_wptr !== 4'b1000 || overflow !== 1'b1) begin
                bad++;
                $display("FAIL ovf_hold%0d b=%b ovf=%b want b=1000 ovf=1",
                         i, b_wptr, overflow);
            end
        end
        for (int r = 1; r <= 10; r++) begin
            drive(0, (r > 8) ? 8 : r);
            tick();
        end
        total++;
        if (overflow !== 1'b1 || wr_count !== 4'd0 ||
            dut_vec() !== exp_vec()) begin
            bad++;
            $display("FAIL ovf_sticky got=%h want=%h", dut_vec(), exp_vec());
        end
    endtask

    task automatic test_drain();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            drive(1, 0);
            tick();
        end
        drive(0, 1);
        tick();
        total++;
        if (full !== 1'b1 || wr_count !== 4'd8) begin
            bad++;
            $display("FAIL drain_edge1 full=%b cnt=%0d want 1 8",
                     full, wr_count);
        end
        drive(0, 1);
        tick();
        total++;
        if (full !== 1'b0 || wr_count !== 4'd7 || almost_full !== 1'b1) begin
            bad++;
            $display("FAIL drain_edge2 full=%b cnt=%0d af=%b want 0 7 1",
                     full, wr_count, almost_full);
        end
    endtask

    task automatic test_wrap();
        logic [3:0] prev_b;
        bit wrapped;
        wrapped = 0;
        do_reset();
        for (int i = 0; i < 20; i++) begin
            prev_b = b_wptr;
            drive(1, (m_wr >= 4) ? m_wr - 4 : 0);
            tick();
            if (prev_b == 4'hf && b_wptr == 4'h0 &&
                g_wptr == 4'b0000) wrapped = 1;
            total++;
            if (full !== 1'b0 || wr_count > 4'd8 ||
                dut_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL wrap_step%0d got=%h want=%h",
                         i, dut_vec(), exp_vec());
            end
        end
        total++;
        if (b_wptr !== 4'd4 || !wrapped) begin
            bad++;
            $display("FAIL wrap_end b=%b wrapped=%0d want b=0100 wrapped=1",
                     b_wptr, wrapped);
        end
    endtask

    task automatic test_random();
        int rd;
        do_reset();
        rd = 0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 2) == 0 && rd < m_wr) rd++;
            drive($urandom_range(0, 3) != 0, rd);
            total++;
            if (mem_we !== exp_we) begin
                bad++;
                $display("FAIL rand_we%0d got=%b want=%b", i, mem_we, exp_we);
            end
            tick();
            total++;
            if (dut_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL rand_state%0d got=%h want=%h",
                         i, dut_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_midreset();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(1, 0);
            tick();
        end
        #2;
        wrst_n = 0;
        model_reset();
        g_rptr_async = '0;
        #1;
        total++;
        if (dut_vec() !== 15'd0) begin
            bad++;
            $display("FAIL midreset_clear got=%h want=0", dut_vec());
        end
        #1;
        wrst_n = 1;
        drive(1, 0);
        total++;
        if (mem_we !== 1'b1 || b_wptr !== 4'd0) begin
            bad++;
            $display("FAIL midreset_addr we=%b b=%b want we=1 b=0000",
                     mem_we, b_wptr);
        end
        tick();
        total++;
        if (dut_vec() !== exp_vec() || b_wptr !== 4'd1) begin
            bad++;
            $display("FAIL midreset_next got=%h want=%h",
                     dut_vec(), exp_vec());
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_overflow();
        test_drain();
        test_wrap();
        test_random();
        test_midreset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fifo_wr_ctrl.md
# fifo_wr_ctrl

Write-side control for the asynchronous FIFO: owns the write pointer, resynchronises the read-domain Gray pointer into the write clock, and produces full, almost-full, fill count and overflow status. It sits directly upstream of `fifo_mem`. Its `b_wptr` and `mem_we` drive the memory's `b_wptr` and `w_en`. Its `g_wptr` goes to the read-side controller through that side's synchroniser.

## Interface
- `DEPTH`, 8, FIFO entries; must equal 2**PTR_WIDTH.
- `PTR_WIDTH`, 3, address bits; pointers are PTR_WIDTH+1 bits (extra wrap bit).
- `AFULL_THRESH`, 6, almost_full asserts when fill count ≥ this; legal range 1..DEPTH.
- `wclk`  in  1  write clock; the only clock in the block.
- `wrst_n`  in  1  asynchronous, active-low reset.
- `w_en`  in  1  write request from producer.
- `g_rptr_async`  in  PTR_WIDTH+1  read pointer, Gray-coded, read-clock domain.
- `mem_we`  out  1  memory write enable = w_en & ~full (combinational).
- `b_wptr`  out  PTR_WIDTH+1  binary write pointer (registered).
- `g_wptr`  out  PTR_WIDTH+1  Gray write pointer (registered), = b_wptr ^ (b_wptr >> 1).
- `full`  out  1  FIFO full (registered).
- `almost_full`  out  1  fill count ≥ AFULL_THRESH (registered).
- `wr_count`  out  PTR_WIDTH+1  entries occupied as seen from write domain, 0..DEPTH (registered).
- `overflow`  out  1  sticky: a write was attempted while full.

## Operation
- Reset (wrst_n low, asynchronous): b_wptr=0, g_wptr=0, both sync stages=0, full=0, almost_full=0, wr_count=0, overflow=0. mem_we then follows w_en.
- Synchroniser: two flops, s1<=g_rptr_async, s2<=s1 each wclk edge. No other logic sits between s1 and s2.
- Accepted write: mem_we=1. b_wptr_next=b_wptr+1 mod 2**(PTR_WIDTH+1); else b_wptr_next=b_wptr. g_wptr_next=Gray(b_wptr_next).
- The memory writes at address b_wptr[PTR_WIDTH-1:0] on the same edge that the pointer advances.
- Status registers are computed from b_wptr_next and s1, i.e. the values b_wptr and s2 take at that edge:
  - full <= (g_wptr_next == {~s1[P:P-1], s1[P-2:0]}), where P=PTR_WIDTH.
  - wr_count <= b_wptr_next − Gray2Bin(s1), mod 2**(P+1).
  - almost_full <= (that count ≥ AFULL_THRESH).
- Status is therefore always consistent with the registered b_wptr and s2.
- Write while full: mem_we=0, pointer holds, overflow<=1. Overflow clears only on reset.
- Simultaneous write and read-pointer advance: both apply in the same computation. The count changes by +1 for the write and −k for the synchronised read movement.
- Wrap-around: b_wptr wraps 2**(P+1)−1 → 0. The Gray code changes one bit per step; the MSB toggles every DEPTH writes.
- Full is conservative: it may stay asserted after the reader frees space, but it never deasserts early. The FIFO never over-writes unread data.

## Timing
- Write acceptance has zero latency: mem_we is combinational from w_en and registered full.
- After an accepted write, b_wptr, g_wptr, full, almost_full and wr_count all update on that same wclk edge.
- Read-pointer change → status: g_rptr_async is captured in s1 at edge 1. full, almost_full and wr_count reflect it at edge 2.
- g_rptr_async must change at most one bit per read clock. This holds by construction of Gray coding.
- Reset deassertion must be synchronous to wclk. It is released through an external reset synchroniser; the block itself only applies reset asynchronously.

## Test plan
- Reset: hold wrst_n=0 with w_en=1 and random g_rptr_async → all registered outputs 0 and mem_we=1. Release reset; the first edge with w_en=1 gives b_wptr=1, g_wptr=0001.
- Fill: g_rptr_async=0000, 8 consecutive writes → almost_full=1 after the 6th edge. After the 8th edge: full=1, wr_count=8, b_wptr=1000, g_wptr=1100.
- Overflow: from full, assert w_en for 3 cycles → mem_we=0, b_wptr stays 1000, overflow=1. Overflow remains 1 after reads drain the FIFO.
- Drain visibility: from full, step g_rptr_async 0000→0001 → full=0 and wr_count=7 exactly 2 edges later. almost_full stays 1.
- Wrap: 20 writes with g_rptr_async tracking each write 4 cycles behind → b_wptr runs 1111→0000 and g_wptr runs 1000→0000. full never asserts, and wr_count stays between 0 and 8 throughout.
- Mid-operation reset: after 5 writes, pulse wrst_n low between edges → outputs clear immediately, without waiting for a wclk edge. The next write after release lands at address 0.
